// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: ID fields, pipeline control, forwarding sources and EX-stage outputs.
// The master modport belongs to the pipeline controller and the slave modport to the stage itself.
interface id_ex_operand_stage_if #(
   parameter int WIDTH   = 32,
   parameter int RADDR_W = 5
);
   logic               stall;
   logic               flush;
   logic               id_valid;
   logic [RADDR_W-1:0] id_rs;
   logic [RADDR_W-1:0] id_rt;
   logic [RADDR_W-1:0] id_rd;
   logic [WIDTH-1:0]   id_rs_data;
   logic [WIDTH-1:0]   id_rt_data;
   logic [WIDTH-1:0]   id_imm;
   logic [4:0]         id_shamt;
   logic [2:0]         id_alu_f;
   logic               id_alu_src;
   logic               id_reg_dst;
   logic               id_reg_write;
   logic               id_mem_read;
   logic               id_mem_write;
   logic               id_uses_rt;
   logic               exm_reg_write;
   logic [RADDR_W-1:0] exm_dest;
   logic [WIDTH-1:0]   exm_result;
   logic               mwb_reg_write;
   logic [RADDR_W-1:0] mwb_dest;
   logic [WIDTH-1:0]   mwb_result;
   logic [WIDTH-1:0]   alu_a;
   logic [WIDTH-1:0]   alu_b;
   logic [2:0]         alu_f;
   logic [4:0]         alu_shamt;
   logic [WIDTH-1:0]   ex_store_data;
   logic [RADDR_W-1:0] ex_dest;
   logic               ex_reg_write;
   logic               ex_mem_read;
   logic               ex_mem_write;
   logic               ex_valid;
   logic               hazard_stall;

   modport master (
      output stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_alu_f, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
             id_mem_write, id_uses_rt, exm_reg_write, exm_dest, exm_result,
             mwb_reg_write, mwb_dest, mwb_result,
      input  alu_a, alu_b, alu_f, alu_shamt, ex_store_data, ex_dest, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_valid, hazard_stall
   );

   modport slave (
      input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_alu_f, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
             id_mem_write, id_uses_rt, exm_reg_write, exm_dest, exm_result,
             mwb_reg_write, mwb_dest, mwb_result,
      output alu_a, alu_b, alu_f, alu_shamt, ex_store_data, ex_dest, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_valid, hazard_stall
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use stall detection.
// ALU operands are selected combinationally from the registered state and the live forwarding sources.
module id_ex_operand_stage #(
   parameter int WIDTH   = 32,
   parameter int RADDR_W = 5
) (
   input logic                   clk,
   input logic                   rst,
   id_ex_operand_stage_if.slave  bus
);

   logic               valid_q;
   logic [RADDR_W-1:0] rs_q;
   logic [RADDR_W-1:0] rt_q;
   logic [RADDR_W-1:0] dest_q;
   logic [WIDTH-1:0]   rs_data_q;
   logic [WIDTH-1:0]   rt_data_q;
   logic [WIDTH-1:0]   imm_q;
   logic [4:0]         shamt_q;
   logic [2:0]         f_q;
   logic               alu_src_q;
   logic               reg_write_q;
   logic               mem_read_q;
   logic               mem_write_q;

   logic               hazard;
   logic [WIDTH-1:0]   fwd_rs;
   logic [WIDTH-1:0]   fwd_rt;

   // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time.
   always_comb begin
      hazard = 1'b0;
      if (bus.id_valid && valid_q && mem_read_q && (dest_q != '0)) begin
         hazard = (dest_q == bus.id_rs) || (bus.id_uses_rt && (dest_q == bus.id_rt));
      end
   end

   always_comb begin
      fwd_rs = rs_data_q;
      if (rs_q == '0)
         fwd_rs = '0;
      else if (bus.exm_reg_write && (bus.exm_dest == rs_q))
         fwd_rs = bus.exm_result;
      else if (bus.mwb_reg_write && (bus.mwb_dest == rs_q))
         fwd_rs = bus.mwb_result;

      fwd_rt = rt_data_q;
      if (rt_q == '0)
         fwd_rt = '0;
      else if (bus.exm_reg_write && (bus.exm_dest == rt_q))
         fwd_rt = bus.exm_result;
      else if (bus.mwb_reg_write && (bus.mwb_dest == rt_q))
         fwd_rt = bus.mwb_result;
   end

   // Bubbles also clear the data registers so an empty slot never presents stale operands.
   always_ff @(posedge clk) begin
      if (rst || (!bus.stall && (bus.flush || hazard))) begin
         valid_q     <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         dest_q      <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         shamt_q     <= '0;
         f_q         <= '0;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else if (!bus.stall) begin
         valid_q     <= bus.id_valid;
         rs_q        <= bus.id_rs;
         rt_q        <= bus.id_rt;
         dest_q      <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
         rs_data_q   <= bus.id_rs_data;
         rt_data_q   <= bus.id_rt_data;
         imm_q       <= bus.id_imm;
         shamt_q     <= bus.id_shamt;
         f_q         <= bus.id_alu_f;
         alu_src_q   <= bus.id_alu_src;
         reg_write_q <= bus.id_reg_write;
         mem_read_q  <= bus.id_mem_read;
         mem_write_q <= bus.id_mem_write;
      end
   end

   assign bus.alu_a         = fwd_rs;
   assign bus.alu_b         = alu_src_q ? imm_q : fwd_rt;
   assign bus.ex_store_data = fwd_rt;
   assign bus.alu_f         = f_q;
   assign bus.alu_shamt     = shamt_q;
   assign bus.ex_dest       = valid_q ? dest_q : '0;
   assign bus.ex_reg_write  = valid_q & reg_write_q;
   assign bus.ex_mem_read   = valid_q & mem_read_q;
   assign bus.ex_mem_write  = valid_q & mem_write_q;
   assign bus.ex_valid      = valid_q;
   assign bus.hazard_stall  = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed vector table for forwarding/hazard/stall corners,
// then randomized traffic compared against a cycle-level reference model of the EX slot.
module tb_id_ex_operand_stage;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   id_ex_operand_stage_if #(.WIDTH(32), .RADDR_W(5)) bus ();

   id_ex_operand_stage #(.WIDTH(32), .RADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct packed {
      logic        do_edge;
      logic        stall;
      logic        flush;
      logic        id_valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [2:0]  f;
      logic        alu_src;
      logic        reg_dst;
      logic        reg_write;
      logic        mem_read;
      logic        uses_rt;
      logic        exm_we;
      logic [4:0]  exm_dest;
      logic [31:0] exm_res;
      logic        mwb_we;
      logic [4:0]  mwb_dest;
      logic [31:0] mwb_res;
      logic        chk_data;
      logic [31:0] e_a;
      logic [31:0] e_b;
      logic [31:0] e_sd;
      logic [2:0]  e_f;
      logic [4:0]  e_dest;
      logic        e_valid;
      logic        e_rw;
      logic        e_hz;
   } vec_t;

   // Reference view of what instruction currently sits in EX.
   typedef struct {
      logic        valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [4:0]  shamt;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [2:0]  f;
      logic        alu_src;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        data_known;
   } ex_model_t;

   ex_model_t ms;
   vec_t      tbl[$];

   function automatic ex_model_t model_empty(input logic known);
      ex_model_t m;
      m.valid = 0; m.rs = 0; m.rt = 0; m.dest = 0; m.shamt = 0;
      m.rs_data = 0; m.rt_data = 0; m.imm = 0; m.f = 0;
      m.alu_src = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      m.data_known = known;
      return m;
   endfunction

   function automatic logic model_hazard();
      if (!bus.id_valid || !ms.valid || !ms.mr || ms.dest == 5'd0) return 1'b0;
      return (ms.dest == bus.id_rs) || (bus.id_uses_rt && ms.dest == bus.id_rt);
   endfunction

   function automatic logic [31:0] model_operand(input logic [4:0] src, input logic [31:0] rf);
      if (src == 5'd0) return 32'd0;
      if (bus.exm_reg_write && bus.exm_dest == src) return bus.exm_result;
      if (bus.mwb_reg_write && bus.mwb_dest == src) return bus.mwb_result;
      return rf;
   endfunction

   // Advance one clock edge, moving the model by the same priority rules as the pipeline.
   task automatic tick();
      ex_model_t nx;
      nx = ms;
      if (rst) begin
         nx = model_empty(1'b1);
      end else if (bus.stall) begin
         nx = ms;
      end else if (bus.flush || model_hazard()) begin
         nx = model_empty(1'b0);
      end else begin
         nx.valid   = bus.id_valid;
         nx.rs      = bus.id_rs;
         nx.rt      = bus.id_rt;
         nx.dest    = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
         nx.shamt   = bus.id_shamt;
         nx.rs_data = bus.id_rs_data;
         nx.rt_data = bus.id_rt_data;
         nx.imm     = bus.id_imm;
         nx.f       = bus.id_alu_f;
         nx.alu_src = bus.id_alu_src;
         nx.rw      = bus.id_reg_write;
         nx.mr      = bus.id_mem_read;
         nx.mw      = bus.id_mem_write;
         nx.data_known = 1'b1;
      end
      @(posedge clk);
      ms = nx;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkModel(input string tag);
      logic [31:0] fwd_rt;
      checkOutput({tag, "_valid"}, 32'(bus.ex_valid), 32'(ms.valid));
      checkOutput({tag, "_dest"}, 32'(bus.ex_dest), ms.valid ? 32'(ms.dest) : 32'd0);
      checkOutput({tag, "_f"}, 32'(bus.alu_f), 32'(ms.f));
      checkOutput({tag, "_shamt"}, 32'(bus.alu_shamt), 32'(ms.shamt));
      checkOutput({tag, "_rw"}, 32'(bus.ex_reg_write), 32'(ms.valid & ms.rw));
      checkOutput({tag, "_mr"}, 32'(bus.ex_mem_read), 32'(ms.valid & ms.mr));
      checkOutput({tag, "_mw"}, 32'(bus.ex_mem_write), 32'(ms.valid & ms.mw));
      checkOutput({tag, "_hz"}, 32'(bus.hazard_stall), 32'(model_hazard()));
      if (ms.data_known) begin
         fwd_rt = model_operand(ms.rt, ms.rt_data);
         checkOutput({tag, "_a"}, bus.alu_a, model_operand(ms.rs, ms.rs_data));
         checkOutput({tag, "_b"}, bus.alu_b, ms.alu_src ? ms.imm : fwd_rt);
         checkOutput({tag, "_sd"}, bus.ex_store_data, fwd_rt);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst               = 1'b0;
      bus.stall         = v.stall;
      bus.flush         = v.flush;
      bus.id_valid      = v.id_valid;
      bus.id_rs         = v.rs;
      bus.id_rt         = v.rt;
      bus.id_rd         = v.rd;
      bus.id_rs_data    = v.rs_data;
      bus.id_rt_data    = v.rt_data;
      bus.id_imm        = v.imm;
      bus.id_shamt      = 5'd0;
      bus.id_alu_f      = v.f;
      bus.id_alu_src    = v.alu_src;
      bus.id_reg_dst    = v.reg_dst;
      bus.id_reg_write  = v.reg_write;
      bus.id_mem_read   = v.mem_read;
      bus.id_mem_write  = 1'b0;
      bus.id_uses_rt    = v.uses_rt;
      bus.exm_reg_write = v.exm_we;
      bus.exm_dest      = v.exm_dest;
      bus.exm_result    = v.exm_res;
      bus.mwb_reg_write = v.mwb_we;
      bus.mwb_dest      = v.mwb_dest;
      bus.mwb_result    = v.mwb_res;
   endtask

   task automatic randomInputs(input logic with_reset);
      rst               = with_reset ? 1'b1 : ($urandom_range(0, 49) == 0);
      bus.stall         = ($urandom_range(0, 4) == 0);
      bus.flush         = ($urandom_range(0, 7) == 0);
      bus.id_valid      = ($urandom_range(0, 5) != 0);
      bus.id_rs         = 5'($urandom_range(0, 7));
      bus.id_rt         = 5'($urandom_range(0, 7));
      bus.id_rd         = 5'($urandom_range(0, 7));
      bus.id_rs_data    = $urandom;
      bus.id_rt_data    = $urandom;
      bus.id_imm        = $urandom;
      bus.id_shamt      = 5'($urandom_range(0, 31));
      bus.id_alu_f      = 3'($urandom_range(0, 7));
      bus.id_alu_src    = 1'($urandom_range(0, 1));
      bus.id_reg_dst    = 1'($urandom_range(0, 1));
      bus.id_reg_write  = 1'($urandom_range(0, 1));
      bus.id_mem_read   = ($urandom_range(0, 2) == 0);
      bus.id_mem_write  = ($urandom_range(0, 3) == 0);
      bus.id_uses_rt    = 1'($urandom_range(0, 1));
      bus.exm_reg_write = 1'($urandom_range(0, 1));
      bus.exm_dest      = 5'($urandom_range(0, 7));
      bus.exm_result    = $urandom;
      bus.mwb_reg_write = 1'($urandom_range(0, 1));
      bus.mwb_dest      = 5'($urandom_range(0, 7));
      bus.mwb_result    = $urandom;
   endtask

   initial begin
      vec_t c;
      checks = 0;
      errors = 0;
      ms = model_empty(1'b1);

      // Directed vectors: each row is applied, optionally clocked, then compared.
      c = '0;
      c.do_edge = 1; c.id_valid = 1; c.rs = 5; c.rt = 6; c.rd = 10;
      c.rs_data = 32'h11; c.rt_data = 32'h44; c.reg_dst = 1; c.reg_write = 1; c.uses_rt = 1;
      c.exm_we = 1; c.exm_dest = 5; c.exm_res = 32'h22; c.mwb_we = 1; c.mwb_dest = 5; c.mwb_res = 32'h33;
      c.chk_data = 1; c.e_a = 32'h22; c.e_b = 32'h44; c.e_sd = 32'h44; c.e_f = 0; c.e_dest = 10;
      c.e_valid = 1; c.e_rw = 1; c.e_hz = 0;
      tbl.push_back(c);
      c.stall = 1; c.exm_we = 0; c.e_a = 32'h33;
      tbl.push_back(c);
      c.mwb_we = 0; c.e_a = 32'h11;
      tbl.push_back(c);
      c.stall = 0; c.rs = 0; c.rt = 7; c.rs_data = 32'h55; c.rt_data = 32'h99; c.reg_dst = 0;
      c.alu_src = 1; c.imm = 32'hFFFF_FFFC; c.f = 3'b010;
      c.exm_we = 1; c.exm_dest = 0; c.exm_res = 32'hDEAD; c.mwb_we = 1; c.mwb_dest = 7; c.mwb_res = 32'h7;
      c.e_a = 0; c.e_b = 32'hFFFF_FFFC; c.e_sd = 32'h7; c.e_f = 3'b010; c.e_dest = 7;
      tbl.push_back(c);
      c.rs = 3; c.rt = 8; c.rs_data = 32'h100; c.rt_data = 0; c.imm = 4; c.alu_src = 1; c.reg_dst = 0;
      c.mem_read = 1; c.uses_rt = 0; c.f = 0; c.exm_we = 0; c.mwb_we = 0;
      c.e_a = 32'h100; c.e_b = 4; c.e_sd = 0; c.e_f = 0; c.e_dest = 8;
      tbl.push_back(c);
      c.do_edge = 0; c.id_valid = 0; c.rs = 9; c.rt = 8; c.uses_rt = 1; c.mem_read = 0; c.e_hz = 0;
      tbl.push_back(c);
      c.id_valid = 1; c.e_hz = 1;
      tbl.push_back(c);
      c.do_edge = 1; c.chk_data = 0; c.e_valid = 0; c.e_dest = 0; c.e_rw = 0; c.e_f = 0; c.e_hz = 0;
      tbl.push_back(c);
      c.rs = 1; c.rt = 2; c.rd = 12; c.rs_data = 32'hA; c.rt_data = 32'hB; c.reg_dst = 1; c.alu_src = 0;
      c.f = 3'b011; c.chk_data = 1; c.e_a = 32'hA; c.e_b = 32'hB; c.e_sd = 32'hB; c.e_f = 3'b011;
      c.e_dest = 12; c.e_valid = 1; c.e_rw = 1;
      tbl.push_back(c);
      c.stall = 1; c.flush = 1; c.rs = 4; c.rt = 4; c.rd = 13; c.rs_data = 32'hC; c.rt_data = 32'hD; c.f = 3'b001;
      tbl.push_back(c);
      c.stall = 0; c.chk_data = 0; c.e_valid = 0; c.e_dest = 0; c.e_rw = 0; c.e_f = 0;
      tbl.push_back(c);
      c.flush = 0; c.rs = 2; c.rt = 3; c.rd = 20; c.reg_dst = 0; c.f = 3'b111; c.rs_data = 1; c.rt_data = 2;
      c.exm_we = 1; c.exm_dest = 3; c.exm_res = 32'h77; c.mwb_we = 1; c.mwb_dest = 2; c.mwb_res = 32'h66;
      c.chk_data = 1; c.e_a = 32'h66; c.e_b = 32'h77; c.e_sd = 32'h77; c.e_f = 3'b111; c.e_dest = 3;
      c.e_valid = 1; c.e_rw = 1;
      tbl.push_back(c);

      // Reset held for two edges with random inputs.
      randomInputs(1'b1);
      #2;
      tick();
      randomInputs(1'b1);
      tick();
      checkOutput("reset_valid", 32'(bus.ex_valid), 32'd0);
      checkOutput("reset_f", 32'(bus.alu_f), 32'd0);
      checkOutput("reset_a", bus.alu_a, 32'd0);
      checkOutput("reset_b", bus.alu_b, 32'd0);
      checkOutput("reset_dest", 32'(bus.ex_dest), 32'd0);
      checkOutput("reset_rw", 32'(bus.ex_reg_write), 32'd0);
      checkOutput("reset_hz", 32'(bus.hazard_stall), 32'd0);

      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         if (tbl[i].do_edge) tick();
         else #2;
         checkOutput($sformatf("vec%0d_valid", i), 32'(bus.ex_valid), 32'(tbl[i].e_valid));
         checkOutput($sformatf("vec%0d_dest", i), 32'(bus.ex_dest), 32'(tbl[i].e_dest));
         checkOutput($sformatf("vec%0d_f", i), 32'(bus.alu_f), 32'(tbl[i].e_f));
         checkOutput($sformatf("vec%0d_rw", i), 32'(bus.ex_reg_write), 32'(tbl[i].e_rw));
         checkOutput($sformatf("vec%0d_hz", i), 32'(bus.hazard_stall), 32'(tbl[i].e_hz));
         if (tbl[i].chk_data) begin
            checkOutput($sformatf("vec%0d_a", i), bus.alu_a, tbl[i].e_a);
            checkOutput($sformatf("vec%0d_b", i), bus.alu_b, tbl[i].e_b);
            checkOutput($sformatf("vec%0d_sd", i), bus.ex_store_data, tbl[i].e_sd);
         end
      end

      // Randomized traffic: compare before each edge (combinational paths) and after it.
      for (int n = 0; n < 600; n++) begin
         randomInputs(1'b0);
         #2;
         checkModel($sformatf("rnd%0d_pre", n));
         tick();
         checkModel($sformatf("rnd%0d_post", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
